// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and storage-register signals of the shared-register write arbiter
interface mem_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 35
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    ack;
    logic                mem_wren;
    logic [DW-1:0]       mem_din;
    logic [DW-1:0]       mem_dout;
    logic                busy;
    logic                err;
    logic [15:0]         wr_count;

    modport slave (
        input  req, wdata, mem_dout,
        output ack, mem_wren, mem_din, busy, err, wr_count
    );

    modport master (
        output req, wdata, mem_dout,
        input  ack, mem_wren, mem_din, busy, err, wr_count
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin write arbiter for one shared storage register with readback check
module mem_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 35
) (
    input  logic          clk,
    input  logic          arst_n,
    mem_arbiter_if.slave  bus
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, WRITE, CHECK} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
    logic [PW-1:0]    win_sel;
    logic             found;
    logic [DW-1:0]    data_q, data_d;
    logic [N_REQ-1:0] ack_q;
    logic             wren_q;
    logic [DW-1:0]    din_q;
    logic             busy_q;
    logic             err_q;
    logic [15:0]      count_q;
    int               idx;

    // First set request at or above ptr, wrapping modulo N_REQ
    always_comb begin
        found   = 1'b0;
        win_sel = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && bus.req[idx]) begin
                found   = 1'b1;
                win_sel = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = WRITE;
                    win_d   = win_sel;
                    data_d  = bus.wdata[int'(win_sel)*DW +: DW];
                    ptr_d   = (int'(win_sel) == N_REQ-1) ? '0 : win_sel + 1'b1;
                end
            end
            WRITE:   state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            data_q  <= data_d;
        end
    end

    // Outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ack_q   <= '0;
            wren_q  <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            ack_q  <= (state_d == CHECK) ? (N_REQ'(1) << win_d) : '0;
            wren_q <= (state_d == WRITE);
            din_q  <= data_d;
            busy_q <= (state_d != IDLE);
            if (state_q == CHECK) begin
                if (bus.mem_dout != data_q) err_q <= 1'b1;
                if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.ack      = ack_q;
    assign bus.mem_wren = wren_q;
    assign bus.mem_din  = din_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.wr_count = count_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a behavioural storage register
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int DW = 35;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();
    mem_arbiter #(.N_REQ(N), .DW(DW)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

    logic [DW-1:0] mem_q;
    logic          zero_dout;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)           mem_q <= '0;
        else if (bus.mem_wren) mem_q <= bus.mem_din;
    end
    assign bus.mem_dout = zero_dout ? '0 : mem_q;

    int vectors = 0;
    int misses  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [DW-1:0] v);
        bus.wdata[i*DW +: DW] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_ack;
        bus.req   = '0;
        bus.wdata = '0;
        zero_dout = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_ack", bus.ack, 4'b0000);
        chk("rst_wren", bus.mem_wren, 1'b0);
        chk("rst_din", bus.mem_din, 35'h0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_cnt", bus.wr_count, 16'h0);
        arst_n = 1'b1;
        tick();

        // single request on requester 2; req and wdata change after grant
        set_wd(2, 35'h1_2345_6789);
        bus.req = 4'b0100;
        tick();
        chk("s_wren", bus.mem_wren, 1'b1);
        chk("s_din", bus.mem_din, 35'h1_2345_6789);
        chk("s_busy", bus.busy, 1'b1);
        chk("s_ack_early", bus.ack, 4'b0000);
        set_wd(2, 35'h0_0000_0ABC);
        bus.req = 4'b0000;
        tick();
        chk("s_ack", bus.ack, 4'b0100);
        chk("s_wren_off", bus.mem_wren, 1'b0);
        chk("s_din_hold", bus.mem_din, 35'h1_2345_6789);
        tick();
        chk("s_ack_off", bus.ack, 4'b0000);
        chk("s_err", bus.err, 1'b0);
        chk("s_cnt", bus.wr_count, 16'd1);
        chk("s_busy_off", bus.busy, 1'b0);

        // reset to bring ptr back to 0, then all four requesting
        arst_n = 1'b0;
        tick();
        chk("r2_cnt", bus.wr_count, 16'd0);
        arst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_wd(i, DW'(35'h100 + i));
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_din", bus.mem_din, 35'h100 + i);
            tick();
            exp_ack = 4'b0001 << i;
            chk("rr_ack", bus.ack, exp_ack);
            bus.req[i] = 1'b0;
            tick();
            chk("rr_cnt", bus.wr_count, i + 1);
            chk("rr_busy", bus.busy, 1'b0);
        end

        // req[0] and req[3] held: 0,3,0,3,0
        set_wd(0, 35'h0AA);
        set_wd(3, 35'h3BB);
        bus.req = 4'b1001;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("alt_din", bus.mem_din, (g % 2 == 0) ? 35'h0AA : 35'h3BB);
            tick();
            chk("alt_ack", bus.ack, (g % 2 == 0) ? 4'b0001 : 4'b1000);
            if (g == 4) bus.req = 4'b0000;
            tick();
        end
        chk("alt_cnt", bus.wr_count, 16'd9);

        // readback mismatch makes err sticky
        set_wd(1, 35'h7_FFFF_FFFF);
        bus.req   = 4'b0010;
        zero_dout = 1'b1;
        tick();
        chk("e_din", bus.mem_din, 35'h7_FFFF_FFFF);
        tick();
        chk("e_ack", bus.ack, 4'b0010);
        chk("e_err_pre", bus.err, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk("e_err", bus.err, 1'b1);
        zero_dout = 1'b0;
        set_wd(2, 35'h5);
        bus.req = 4'b0100;
        tick(); tick();
        chk("e2_ack", bus.ack, 4'b0100);
        bus.req = 4'b0000;
        tick();
        chk("e2_err_sticky", bus.err, 1'b1);
        chk("e2_cnt", bus.wr_count, 16'd11);

        // asynchronous reset during WRITE aborts the transaction
        set_wd(0, 35'h1234);
        bus.req = 4'b0001;
        tick();
        chk("a_wren", bus.mem_wren, 1'b1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("a_wren_drop", bus.mem_wren, 1'b0);
        chk("a_busy", bus.busy, 1'b0);
        chk("a_ack", bus.ack, 4'b0000);
        chk("a_cnt", bus.wr_count, 16'd0);
        chk("a_err", bus.err, 1'b0);
        bus.req = 4'b0000;
        #1;
        arst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_no_ack", bus.ack, 4'b0000);
        end
        chk("a_cnt_after", bus.wr_count, 16'd0);

        // request pending at reset release is granted from ptr 0
        set_wd(1, 35'h11);
        set_wd(3, 35'h33);
        bus.req = 4'b1010;
        arst_n  = 1'b0;
        tick();
        arst_n = 1'b1;
        tick();
        chk("rel_din", bus.mem_din, 35'h11);
        tick();
        chk("rel_ack", bus.ack, 4'b0010);
        bus.req = 4'b0000;
        tick();
        chk("rel_cnt", bus.wr_count, 16'd1);

        // counter saturation, preloaded near the top
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        set_wd(2, 35'h77);
        bus.req = 4'b0100;
        tick(); tick();
        chk("sat_ack1", bus.ack, 4'b0100);
        bus.req = 4'b0000;
        tick();
        chk("sat_cnt1", bus.wr_count, 16'hFFFF);
        bus.req = 4'b0001;
        tick(); tick();
        chk("sat_ack2", bus.ack, 4'b0001);
        bus.req = 4'b0000;
        tick();
        chk("sat_cnt2", bus.wr_count, 16'hFFFF);
        chk("sat_err", bus.err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
